uart_frame_builder: RTL and testbench

UART_FRAME_BUILDER -- requirements
Module: uart_frame_builder

---
 rtl/uart_fmt_pkg.sv | 25 ++
 rtl/uart_frame_builder_if.sv | 21 ++
 rtl/hex_to_ascii.sv | 13 +
 rtl/uart_frame_builder.sv | 122 ++++++++++++
 tb/tb_uart_frame_builder.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_fmt_pkg.sv
// Shared types and constants for the sensor-sample-to-ASCII frame builder.
package uart_fmt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD,
    WAIT
  } fsm_state_t;

  localparam logic [7:0] ASCII_TAG_P = 8'h50;
  localparam logic [7:0] ASCII_TAG_T = 8'h54;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int unsigned FRAME_LEN_CRLF = 10;
  localparam int unsigned FRAME_LEN_LF   = 9;

  // Index of the final byte of a frame for the chosen terminator.
  function automatic logic [3:0] last_index(input bit use_crlf);
    return use_crlf ? 4'(FRAME_LEN_CRLF - 1) : 4'(FRAME_LEN_LF - 1);
  endfunction

endpackage

// File: rtl/uart_frame_builder_if.sv
// Sample-in / byte-out handshake bundle of the frame builder.
interface uart_frame_builder_if;
  logic        sample_vld;
  logic        sample_sel;
  logic [23:0] sample_data;
  logic        sample_rdy;
  logic        tx_vld;
  logic [7:0]  tx_data;
  logic        tx_rdy;
  logic        frame_done;

  modport master (
    input  sample_vld, sample_sel, sample_data, tx_rdy,
    output sample_rdy, tx_vld, tx_data, frame_done
  );

  modport slave (
    output sample_vld, sample_sel, sample_data, tx_rdy,
    input  sample_rdy, tx_vld, tx_data, frame_done
  );
endinterface

// File: rtl/hex_to_ascii.sv
// One hex nibble to its uppercase ASCII character.
module hex_to_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // '0'..'9' for 0-9, 'A'..'F' for 10-15
  always_comb begin
    if (nibble < 4'd10) ascii = 8'h30 + {4'h0, nibble};
    else                ascii = 8'h37 + {4'h0, nibble};
  end

endmodule

// File: rtl/uart_frame_builder.sv
// Formats a 24-bit sensor sample as "P:XXXXXX\r\n" / "T:XXXXXX\r\n" and feeds
// it byte by byte to the UART transmitter.
module uart_frame_builder
  import uart_fmt_pkg::*;
#(
  parameter bit USE_CRLF = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  uart_frame_builder_if.master bus
);

  localparam logic [3:0] LAST_IDX = last_index(USE_CRLF);

  fsm_state_t  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        sel_q, sel_d;
  logic [23:0] data_q, data_d;
  logic        tx_vld_q, tx_vld_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        done_q, done_d;
  logic [3:0]  nibble;
  logic [7:0]  hex_char;
  logic [7:0]  frame_byte;

  // Hex digit positions 2..7 walk the held sample MS nibble first
  always_comb begin
    case (idx_q)
      4'd2:    nibble = data_q[23:20];
      4'd3:    nibble = data_q[19:16];
      4'd4:    nibble = data_q[15:12];
      4'd5:    nibble = data_q[11:8];
      4'd6:    nibble = data_q[7:4];
      4'd7:    nibble = data_q[3:0];
      default: nibble = '0;
    endcase
  end

  hex_to_ascii u_hex (
    .nibble(nibble),
    .ascii (hex_char)
  );

  // Byte to send at the current index
  always_comb begin
    case (idx_q)
      4'd0:    frame_byte = sel_q ? ASCII_TAG_T : ASCII_TAG_P;
      4'd1:    frame_byte = ASCII_COLON;
      4'd8:    frame_byte = USE_CRLF ? ASCII_CR : ASCII_LF;
      4'd9:    frame_byte = ASCII_LF;
      default: frame_byte = hex_char;
    endcase
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sel_d     = sel_q;
    data_d    = data_q;
    tx_vld_d  = 1'b0;
    tx_data_d = tx_data_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.sample_vld) begin
          sel_d   = bus.sample_sel;
          data_d  = bus.sample_data;
          idx_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.tx_rdy) begin
          tx_vld_d  = 1'b1;
          tx_data_d = frame_byte;
          state_d   = HOLD;
        end
      end
      HOLD: state_d = WAIT;
      WAIT: begin
        if (bus.tx_rdy) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, index, holding and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      sel_q     <= 1'b0;
      data_q    <= '0;
      tx_vld_q  <= 1'b0;
      tx_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      data_q    <= data_d;
      tx_vld_q  <= tx_vld_d;
      tx_data_q <= tx_data_d;
      done_q    <= done_d;
    end
  end

  assign bus.sample_rdy = (state_q == IDLE);
  assign bus.tx_vld     = tx_vld_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_uart_frame_builder.sv
// Scoreboard bench: CRLF (ch0) and LF-only (ch1) builders, each with a
// randomly busy transmitter model.
module tb_uart_frame_builder;

  logic clk;
  logic rst_n;
  logic tx_stall;
  logic done_req;
  int   to_cnt;

  int unsigned busy0, busy1;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  int   n_chk;
  int   n_fail;
  int   cyc;

  int   ptr[2];
  int   nbytes[2];
  int   lat[2];
  logic active[2];
  logic armed[2];
  logic rdy_issue[2];
  logic prev_vld[2];
  logic prev_rdy[2];
  logic prev_done[2];
  logic [7:0] last_b[2];
  logic prev_rst;
  logic prev_stall;
  int   stall_vld;

  uart_frame_builder_if bus0 ();
  uart_frame_builder_if bus1 ();

  uart_frame_builder #(.USE_CRLF(1'b1)) u_dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0.master)
  );

  uart_frame_builder #(.USE_CRLF(1'b0)) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter models: busy for a random time after each byte
  always @(posedge clk) begin
    if (bus0.tx_vld) busy0 <= $urandom_range(0, 4);
    else if (busy0 != 0) busy0 <= busy0 - 1;
    if (bus1.tx_vld) busy1 <= $urandom_range(0, 4);
    else if (busy1 != 0) busy1 <= busy1 - 1;
  end

  assign bus0.tx_rdy = !bus0.tx_vld && (busy0 == 0) && !tx_stall;
  assign bus1.tx_rdy = !bus1.tx_vld && (busy1 == 0);

  // ---------------- reference model ----------------
  function automatic int qsize(input int ch);
    return (ch == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [7:0] qget(input int ch, input int i);
    return (ch == 0) ? q0[i] : q1[i];
  endfunction

  task automatic qpush(input int ch, input logic [7:0] b);
    if (ch == 0) q0.push_back(b);
    else         q1.push_back(b);
  endtask

  // Expected frame: tag, ':', six uppercase hex digits, terminator
  task automatic push_frame(input int ch, input logic sel, input logic [23:0] data);
    logic [7:0] b;
    logic [3:0] nib;
    b = sel ? "T" : "P";
    qpush(ch, b);
    b = ":";
    qpush(ch, b);
    for (int k = 5; k >= 0; k--) begin
      nib = 4'(data >> (4 * k));
      b = (nib < 4'd10) ? "0" + 8'(nib) : "A" + 8'(nib) - 8'd10;
      qpush(ch, b);
    end
    if (ch == 0) qpush(ch, 8'd13);
    qpush(ch, 8'd10);
  endtask

  // ---------------- stimulus ----------------
  function automatic logic srdy(input int ch);
    return (ch == 0) ? bus0.sample_rdy : bus1.sample_rdy;
  endfunction

  task automatic drive(input int ch, input logic v, input logic s, input logic [23:0] d);
    if (ch == 0) begin
      bus0.sample_vld = v; bus0.sample_sel = s; bus0.sample_data = d;
    end else begin
      bus1.sample_vld = v; bus1.sample_sel = s; bus1.sample_data = d;
    end
  endtask

  // Present a sample until accepted; expects to start at posedge+1
  task automatic send(input int ch, input logic sel, input logic [23:0] data);
    int n;
    n = 0;
    drive(ch, 1'b1, sel, data);
    @(negedge clk);
    while (!srdy(ch) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 6000) begin
      to_cnt++;
      drive(ch, 1'b0, 1'b0, 24'h0);
      @(posedge clk);
      #1;
    end else begin
      @(posedge clk);
      push_frame(ch, sel, data);
      #1;
      drive(ch, 1'b0, 1'($urandom), 24'($urandom));
    end
  endtask

  task automatic wait_idle(input int ch);
    int n;
    n = 0;
    @(negedge clk);
    while (!srdy(ch) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) to_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bytes(input int cnt);
    int n;
    int seen;
    n = 0;
    seen = 0;
    while (seen < cnt && n < 2000) begin
      @(negedge clk);
      if (bus0.tx_vld) seen++;
      n++;
    end
    if (seen < cnt) to_cnt++;
  endtask

  task automatic wait_tx_rdy();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus0.tx_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) to_cnt++;
  endtask

  initial begin
    rst_n    = 1'b0;
    tx_stall = 1'b0;
    done_req = 1'b0;
    to_cnt   = 0;
    drive(0, 1'b0, 1'b0, 24'h0);
    drive(1, 1'b0, 1'b0, 24'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // nominal, then LF-only
    send(0, 1'b0, 24'h1A2B3C);
    wait_idle(0);
    send(1, 1'b1, 24'hFFFFFF);
    wait_idle(1);
    // second sample held while busy, accepted in the frame_done cycle
    send(0, 1'b0, 24'hABCDEF);
    send(0, 1'b0, 24'h000001);
    wait_idle(0);
    // long stall with the FSM sitting in ISSUE
    send(0, 1'b1, 24'($urandom));
    wait_bytes(3);
    wait_tx_rdy();
    @(posedge clk);
    #1 tx_stall = 1'b1;
    repeat (1000) @(posedge clk);
    #1 tx_stall = 1'b0;
    wait_idle(0);
    // reset after the 4th byte
    send(0, 1'b0, 24'($urandom));
    wait_bytes(4);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(0, 1'b1, 24'h5A5A5A);
    wait_idle(0);
    // back-to-back random frames
    for (int i = 0; i < 50; i++) send(0, 1'($urandom), 24'($urandom));
    wait_idle(0);
    for (int i = 0; i < 6; i++) send(1, 1'($urandom), 24'($urandom));
    wait_idle(1);
    done_req = 1'b1;
  end

  // ---------------- monitor / checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon_chan(input int ch, input logic svld, input logic srdy_i, input logic vld,
                          input logic [7:0] data, input logic done, input logic rdy);
    if (svld) chk("sample_rdy", 32'(srdy_i), 32'(!active[ch] || done));
    if (armed[ch]) begin
      lat[ch]++;
      if (lat[ch] == 1) rdy_issue[ch] = rdy;
    end
    if (vld) begin
      chk("tx_vld_consecutive", 32'(prev_vld[ch]), 32'(0));
      chk("tx_vld_without_prior_rdy", 32'(prev_rdy[ch]), 32'(1));
      if (armed[ch]) begin
        if (rdy_issue[ch]) chk("first_byte_latency", 32'(lat[ch]), 32'(2));
        armed[ch] = 1'b0;
      end
      if (ptr[ch] < qsize(ch)) begin
        chk("tx_data", 32'(data), 32'(qget(ch, ptr[ch])));
        ptr[ch]++;
      end else begin
        chk("tx_vld_beyond_expected", 32'(ptr[ch]), 32'(qsize(ch)));
      end
      nbytes[ch]++;
      last_b[ch] = data;
    end else begin
      chk("tx_data_hold", 32'(data), 32'(last_b[ch]));
    end
    if (done) begin
      chk("frame_done_width", 32'(prev_done[ch]), 32'(0));
      chk("frame_len", 32'(nbytes[ch]), (ch == 0) ? 32'd10 : 32'd9);
      nbytes[ch] = 0;
      active[ch] = 1'b0;
    end
    if (svld && srdy_i) begin
      active[ch] = 1'b1;
      armed[ch]  = 1'b1;
      lat[ch]    = 0;
    end
    prev_vld[ch]  = vld;
    prev_rdy[ch]  = rdy;
    prev_done[ch] = done;
  endtask

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    prev_rst = 1'b0;
    prev_stall = 1'b0;
    stall_vld = 0;
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("reset_outputs_ch0",
          32'({bus0.tx_vld, bus0.tx_data, bus0.frame_done, bus0.sample_rdy}), 32'h001);
      chk("reset_outputs_ch1",
          32'({bus1.tx_vld, bus1.tx_data, bus1.frame_done, bus1.sample_rdy}), 32'h001);
      for (int c = 0; c < 2; c++) begin
        ptr[c]       = qsize(c);
        nbytes[c]    = 0;
        lat[c]       = 0;
        active[c]    = 1'b0;
        armed[c]     = 1'b0;
        rdy_issue[c] = 1'b0;
        prev_vld[c]  = 1'b0;
        prev_rdy[c]  = 1'b0;
        prev_done[c] = 1'b0;
        last_b[c]    = 8'h00;
      end
    end else begin
      if (!prev_rst) chk("sample_rdy_after_reset", 32'(bus0.sample_rdy), 32'(1));
      mon_chan(0, bus0.sample_vld, bus0.sample_rdy, bus0.tx_vld, bus0.tx_data,
               bus0.frame_done, bus0.tx_rdy);
      mon_chan(1, bus1.sample_vld, bus1.sample_rdy, bus1.tx_vld, bus1.tx_data,
               bus1.frame_done, bus1.tx_rdy);
      if (tx_stall && !prev_stall) stall_vld = 0;
      if (prev_stall && bus0.tx_vld) stall_vld++;
      if (prev_stall && !tx_stall) chk("tx_vld_during_stall", 32'(stall_vld), 32'(0));
    end
    prev_rst   = rst_n;
    prev_stall = tx_stall;
    if (done_req) begin
      chk("ch0_bytes_drained", 32'(ptr[0]), 32'(q0.size()));
      chk("ch1_bytes_drained", 32'(ptr[1]), 32'(q1.size()));
      chk("frames_closed", 32'({active[0], active[1]}), 32'(0));
      chk("stimulus_timeouts", 32'(to_cnt), 32'(0));
      finish_run();
    end else if (cyc > 60000) begin
      chk("watchdog_cycles", 32'(cyc), 32'(60000));
      finish_run();
    end
  end

endmodule
